// File: rtl/key_cmd_if.sv
// Key-event and command bundle between the debouncer side and key_cmd_ctrl.
interface key_cmd_if #(
  parameter int unsigned SPD_W = 8
);
  logic [3:0]       key_flag;
  logic [3:0]       key_value;
  logic [1:0]       mode;
  logic [SPD_W-1:0] speed;
  logic             run_en;
  logic             cmd_valid;
  logic             estop_active;

  modport master (
    output key_flag, key_value,
    input  mode, speed, run_en, cmd_valid, estop_active
  );

  modport slave (
    input  key_flag, key_value,
    output mode, speed, run_en, cmd_valid, estop_active
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// Turns debounced key events into drive mode and speed setpoint, with
// emergency stop, fixed-priority arbitration and hold-to-repeat speed keys.
module key_cmd_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned SPD_W         = 8,
  parameter int unsigned SPD_STEP      = 10,
  parameter int unsigned SPD_MAX       = 250
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  key_cmd_if.slave  bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {MODE_STOP, MODE_FWD, MODE_REV, MODE_AUTO} mode_e;
  typedef enum logic {PH_HOLD, PH_REPEAT} phase_e;

  mode_e            mode_q, mode_n;
  phase_e           phase_q, phase_n;
  logic [SPD_W-1:0] speed_q, speed_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             estop_q, estop_n;
  logic             up_q, up_n, dn_q, dn_n;
  logic             run_en_q, run_en_n;
  logic             cmd_valid_q, cmd_valid_n;

  logic [3:0]       press, release_ev;
  logic             up_rel, dn_rel;
  logic [SPD_W:0]   spd_sum;
  logic [SPD_W-1:0] spd_up, spd_dn;

  assign press      = bus.key_flag & ~bus.key_value;
  assign release_ev = bus.key_flag &  bus.key_value;

  // Saturating step values; one extra bit keeps the up-step from wrapping.
  assign spd_sum = {1'b0, speed_q} + (SPD_W+1)'(SPD_STEP);
  assign spd_up  = (spd_sum > (SPD_W+1)'(SPD_MAX)) ? SPD_W'(SPD_MAX) : spd_sum[SPD_W-1:0];
  assign spd_dn  = (speed_q >= SPD_W'(SPD_STEP)) ? (speed_q - SPD_W'(SPD_STEP)) : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q      <= MODE_STOP;
      phase_q     <= PH_HOLD;
      speed_q     <= '0;
      cnt_q       <= '0;
      estop_q     <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      run_en_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_n;
      phase_q     <= phase_n;
      speed_q     <= speed_n;
      cnt_q       <= cnt_n;
      estop_q     <= estop_n;
      up_q        <= up_n;
      dn_q        <= dn_n;
      run_en_q    <= run_en_n;
      cmd_valid_q <= cmd_valid_n;
    end
  end

  // Priority: estop press > mode key > speed press > auto-repeat.
  always_comb begin
    mode_n  = mode_q;
    phase_n = phase_q;
    speed_n = speed_q;
    cnt_n   = cnt_q;
    estop_n = estop_q;
    up_rel  = up_q & ~release_ev[1];
    dn_rel  = dn_q & ~release_ev[2];
    up_n    = up_rel;
    dn_n    = dn_rel;

    if (press[3]) begin
      mode_n  = MODE_STOP;
      speed_n = '0;
      estop_n = 1'b1;
      up_n    = 1'b0;
      dn_n    = 1'b0;
      cnt_n   = '0;
      phase_n = PH_HOLD;
    end else begin
      if (release_ev[3]) estop_n = 1'b0;
      if (!estop_q && press[0]) begin
        mode_n = mode_e'(mode_q + 2'd1);
      end else if (!estop_q && (press[1] || press[2])) begin
        cnt_n   = '0;
        phase_n = PH_HOLD;
        if (press[1]) up_n = 1'b1;
        if (press[2]) dn_n = 1'b1;
        if (press[1] && !press[2])      speed_n = spd_up;
        else if (press[2] && !press[1]) speed_n = spd_dn;
      end else if (up_rel ^ dn_rel) begin
        if ((up_rel != up_q) || (dn_rel != dn_q)) begin
          cnt_n   = '0;
          phase_n = PH_HOLD;
        end else if ((phase_q == PH_HOLD) && (cnt_q == CNT_W'(HOLD_CYCLES - 1))) begin
          speed_n = up_rel ? spd_up : spd_dn;
          cnt_n   = '0;
          phase_n = PH_REPEAT;
        end else if ((phase_q == PH_REPEAT) && (cnt_q == CNT_W'(REPEAT_CYCLES - 1))) begin
          speed_n = up_rel ? spd_up : spd_dn;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
    end

    if (!up_n && !dn_n) cnt_n = '0;

    run_en_n    = (mode_n != MODE_STOP);
    cmd_valid_n = (mode_n != mode_q) || (speed_n != speed_q);
  end

  assign bus.mode         = mode_q;
  assign bus.speed        = speed_q;
  assign bus.run_en       = run_en_q;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.estop_active = estop_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl: expected command pulses go to a queue that
// a negedge monitor drains; level outputs are checked directly.
module tb_key_cmd_ctrl;

  typedef struct {
    int cyc;
    int mode;
    int speed;
  } exp_t;

  logic sys_clk;
  logic sys_rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  key_cmd_if #(.SPD_W(8)) bus ();

  key_cmd_ctrl #(
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .SPD_W        (8),
    .SPD_STEP     (10),
    .SPD_MAX      (250)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int m, input int s);
    exp_t e;
    e.cyc = c; e.mode = m; e.speed = s;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic [3:0] f, input logic [3:0] v);
    bus.key_flag  = f;
    bus.key_value = v;
    @(posedge sys_clk); #1;
    bus.key_flag  = 4'h0;
  endtask

  task automatic press(input int k);
    logic [3:0] m;
    m = 4'b0001 << k;
    strobe(m, ~m);
  endtask

  task automatic rel(input int k);
    logic [3:0] m;
    m = 4'b0001 << k;
    strobe(m, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  // Scoreboard monitor: every cmd_valid pulse must match the next expectation.
  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1 && bus.cmd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cmd: cycle %0d mode %0d speed %0d, none expected",
                 cyc, bus.mode, bus.speed);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.mode != int'(bus.mode) || e.speed != int'(bus.speed)) begin
          n_fail++;
          $display("FAIL cmd_pulse: got cycle %0d mode %0d speed %0d expected cycle %0d mode %0d speed %0d",
                   cyc, bus.mode, bus.speed, e.cyc, e.mode, e.speed);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;
    sys_rst_n     = 1'b0;
    bus.key_flag  = 4'h0;
    bus.key_value = 4'hF;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_speed", int'(bus.speed), 0);
    chk("rst_run_en", int'(bus.run_en), 0);
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_estop", int'(bus.estop_active), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // 1: mode cycles through FWD, REV, AUTO, STOP
    for (int k = 1; k <= 4; k++) begin
      t = cyc;
      push(t + 1, k % 4, 0);
      press(0);
      chk("t1_mode", int'(bus.mode), k % 4);
      chk("t1_run_en", int'(bus.run_en), (k % 4 != 0) ? 1 : 0);
      rel(0);
      idle(1);
    end
    chk("t1_speed", int'(bus.speed), 0);

    // 2: hold key1, first repeat after HOLD, then every REPEAT cycles
    t = cyc;
    push(t + 1, 0, 10);
    push(t + 21, 0, 20);
    push(t + 26, 0, 30);
    push(t + 31, 0, 40);
    press(1);
    idle(31);
    rel(1);
    idle(20);
    chk("t2_speed", int'(bus.speed), 40);

    // 3: climb to 240, saturate at 250, then descend and floor at 0
    for (int j = 0; j < 20; j++) begin
      t = cyc;
      push(t + 1, 0, 50 + 10 * j);
      press(1);
      rel(1);
    end
    chk("t3_speed240", int'(bus.speed), 240);
    t = cyc;
    push(t + 1, 0, 250);
    press(1);
    idle(29);
    rel(1);
    idle(5);
    chk("t3_sat", int'(bus.speed), 250);
    for (int j = 0; j < 25; j++) begin
      t = cyc;
      push(t + 1, 0, 240 - 10 * j);
      press(2);
      rel(2);
    end
    press(2);
    rel(2);
    idle(3);
    chk("t3_floor", int'(bus.speed), 0);

    // 4: estop beats coincident key0/key1 and locks out keys until release
    t = cyc;
    push(t + 1, 1, 0);
    press(0);
    rel(0);
    for (int j = 0; j < 10; j++) begin
      t = cyc;
      push(t + 1, 1, 10 * (j + 1));
      press(1);
      rel(1);
    end
    chk("t4_speed100", int'(bus.speed), 100);
    t = cyc;
    push(t + 1, 0, 0);
    strobe(4'b1011, 4'b0100);
    chk("t4_estop", int'(bus.estop_active), 1);
    chk("t4_mode", int'(bus.mode), 0);
    chk("t4_speed", int'(bus.speed), 0);
    chk("t4_run_en", int'(bus.run_en), 0);
    press(0);
    rel(0);
    press(1);
    idle(25);
    rel(1);
    chk("t4_lock_mode", int'(bus.mode), 0);
    chk("t4_lock_speed", int'(bus.speed), 0);
    chk("t4_lock_estop", int'(bus.estop_active), 1);
    rel(3);
    chk("t4_estop_rel", int'(bus.estop_active), 0);
    press(3);
    chk("t4_estop_idle", int'(bus.estop_active), 1);
    rel(3);
    chk("t4_estop_idle_rel", int'(bus.estop_active), 0);

    // 5: both speed keys held freeze the counter; releasing one restarts HOLD
    t = cyc;
    push(t + 1, 1, 0);
    press(0);
    rel(0);
    for (int j = 0; j < 3; j++) begin
      t = cyc;
      push(t + 1, 1, 10 * (j + 1));
      press(1);
      rel(1);
    end
    strobe(4'b0110, 4'b1001);
    idle(40);
    chk("t5_both_speed", int'(bus.speed), 30);
    r = cyc;
    push(r + 21, 1, 40);
    push(r + 26, 1, 50);
    push(r + 31, 1, 60);
    push(r + 36, 1, 70);
    strobe(4'b0100, 4'b1101);
    idle(36);
    chk("t5_speed70", int'(bus.speed), 70);

    // 6: asynchronous reset in the middle of REPEAT
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_mode", int'(bus.mode), 0);
    chk("t6_speed", int'(bus.speed), 0);
    chk("t6_run_en", int'(bus.run_en), 0);
    chk("t6_cmd_valid", int'(bus.cmd_valid), 0);
    chk("t6_estop", int'(bus.estop_active), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(30);
    chk("t6_post_speed", int'(bus.speed), 0);
    chk("t6_post_mode", int'(bus.mode), 0);

    chk("pending_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cmd_ctrl.md
Name: key_cmd_ctrl

Overview:
- Command controller that sits directly after the four-key debouncer in the smart-car top level.
- Turns debounced key press/release events into a drive mode and a speed setpoint for the motor/PWM stage.
- Key functions: key0 cycles the mode, key1/key2 step the speed (with hold-to-repeat), key3 is emergency stop.
- Arbitrates simultaneous key events by fixed priority and emits a one-cycle pulse on every effective command change.

Parameters:
- HOLD_CYCLES, 25000000, cycles a speed key must stay held before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_CYCLES, 5000000, auto-repeat period once repeating (100 ms).
- SPD_W, 8, speed setpoint width.
- SPD_STEP, 10, increment/decrement per step.
- SPD_MAX, 250, upper clamp for speed (must be < 2^SPD_W).

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- key_flag  in  4  one-cycle debounce-done strobe per key (bit i = key i)
- key_value  in  4  debounced level per key, valid when matching flag bit is high; 0 = pressed, 1 = released
- mode  out  2  0 STOP, 1 FWD, 2 REV, 3 AUTO
- speed  out  SPD_W  speed setpoint
- run_en  out  1  high when mode != STOP
- cmd_valid  out  1  one-cycle pulse when mode or speed changed this cycle
- estop_active  out  1  high while key3 is held pressed

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low. All state is updated on the sys_clk rising edge.
- Reset values: mode=0, speed=0, run_en=0, cmd_valid=0, estop_active=0; held flags, hold counter and repeat phase are cleared.
- Event decode, for key i:
  - press = key_flag[i] & ~key_value[i]
  - release = key_flag[i] & key_value[i]
- Latency: registered outputs update on the edge after the cycle in which the event is sampled (1 cycle). run_en is registered with mode, so it follows mode in the same cycle.
- Priority when events coincide in one cycle: key3 > key0 > speed keys.
- key3 press:
  - mode <= STOP, speed <= 0, estop_active <= 1.
  - up_held and dn_held are cleared.
  - key0 and speed events in the same cycle are discarded.
- key3 release: estop_active <= 0; nothing else changes.
- While estop_active=1: key0, key1 and key2 presses are ignored. Their held state is not recorded.
- key0 press (no estop): mode advances STOP -> FWD -> REV -> AUTO -> STOP. Speed is unchanged. A speed event in the same cycle is discarded.
- key0 release: no effect.
- Speed step rules:
  - up: speed <= min(speed + SPD_STEP, SPD_MAX).
  - down: speed <= speed - SPD_STEP if speed >= SPD_STEP, else 0.
  - Arithmetic uses SPD_W+1 bits internally, so no wrap-around.
- key1 press: one up step immediately; up_held <= 1; hold counter <= 0; phase <= HOLD.
- key2 press: same as key1, stepping down and setting dn_held.
- Both key1 and key2 press in the same cycle: no step; both held flags are set.
- Release of key1 or key2 clears the corresponding held flag. The counter is cleared whenever neither key is held.
- Auto-repeat applies only when exactly one of up_held/dn_held is 1:
  - The counter increments each cycle.
  - HOLD phase: at count == HOLD_CYCLES-1, one step, counter <= 0, phase <= REPEAT.
  - REPEAT phase: at count == REPEAT_CYCLES-1, one step, counter <= 0.
  - Both held: counter frozen, no steps.
  - Held flags change from one key to the other: counter <= 0, phase <= HOLD.
- Speed changes are allowed in every mode, including STOP.
- cmd_valid = 1 only if the registered mode or speed differs from its previous value. A saturated step, or an estop while already STOP at speed 0, gives no pulse.
- Reset asserted mid-hold or mid-repeat returns to reset values immediately. No step is emitted on reset release.

Test Plan (sim with HOLD_CYCLES=20, REPEAT_CYCLES=5):
1. Reset, then four key0 press strobes 3 cycles apart -> mode 1,2,3,0; run_en 1,1,1,0; cmd_valid pulses 4 times; speed stays 0.
2. key1 press strobe, held 32 cycles, then release -> speed 10 one cycle after the press, 20 at press+21, 30 at +26, 40 at +31; no further steps after release.
3. speed at 240, key1 press, hold 30 cycles -> speed 250 then stays 250; exactly one cmd_valid pulse. At speed 5, key2 press -> 0.
4. Same-cycle strobes of key3 press, key0 press and key1 press with mode=FWD, speed=100 -> mode 0, speed 0, estop_active 1. Following key0/key1 presses are ignored until key3 release.
5. key1 and key2 pressed in the same cycle and held 40 cycles -> no speed change and no cmd_valid. Release key2 -> single-key hold restarts, first repeat step 20 cycles later.
6. Assert sys_rst_n low during REPEAT phase with speed 70 -> all outputs return to 0 asynchronously. After release with no key activity, speed stays 0.
